// File: rtl/store_buffer_pkg.sv
// Shared store-buffer defaults and entry record layout.
// Also imported by bridge_dm for the same entry format.
package store_buffer_pkg;

  localparam int SB_DEPTH_DEFAULT  = 4;
  localparam int SB_ADDR_W_DEFAULT = 32;
  localparam int SB_DATA_W_DEFAULT = 32;
  localparam int SB_BE_W_DEFAULT   = SB_DATA_W_DEFAULT / 8;

  typedef struct packed {
    logic [SB_ADDR_W_DEFAULT-1:0] addr;
    logic [SB_BE_W_DEFAULT-1:0]   be;
    logic [SB_DATA_W_DEFAULT-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fwd_merge.sv
// Youngest-wins lane selector over age-ordered candidates.
// Candidate 0 is the oldest, candidate N-1 the youngest.
module sb_fwd_merge
  import store_buffer_pkg::*;
#(
  parameter int N      = SB_DEPTH_DEFAULT + 1,
  parameter int DATA_W = SB_DATA_W_DEFAULT,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic [N-1:0]        hit,
  input  logic [N*BE_W-1:0]   be,
  input  logic [N*DATA_W-1:0] data,
  output logic [BE_W-1:0]     fwd_be,
  output logic [DATA_W-1:0]   fwd_data
);

  always_comb begin
    fwd_be   = '0;
    fwd_data = '0;
    for (int i = 0; i < N; i++) begin
      for (int l = 0; l < BE_W; l++) begin
        if (hit[i] && be[i*BE_W+l]) begin
          fwd_be[l]          = 1'b1;
          fwd_data[l*8 +: 8] = data[(i*BE_W+l)*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store FIFO between MEM and the data-SRAM bridge with
// tail merging, idle-cycle drain and load forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH_DEFAULT,
  parameter int ADDR_W = SB_ADDR_W_DEFAULT,
  parameter int DATA_W = SB_DATA_W_DEFAULT,
  parameter int BE_W   = DATA_W / 8,
  parameter int WLSB   = $clog2(BE_W),
  parameter int PW     = $clog2(DEPTH),
  parameter int CW     = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [BE_W-1:0]   st_be,
  input  logic [DATA_W-1:0] st_wdata,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [BE_W-1:0]   ld_fwd_be,
  output logic [DATA_W-1:0] ld_fwd_data,
  output logic              sb_wr_valid,
  input  logic              sb_wr_gnt,
  output logic [ADDR_W-1:0] sb_wr_addr,
  output logic [BE_W-1:0]   sb_wr_be,
  output logic [DATA_W-1:0] sb_wr_data,
  output logic [CW-1:0]     sb_count,
  output logic              sb_empty
);

  localparam int WA_W = ADDR_W - WLSB;
  localparam int NC   = DEPTH + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] TWO  = CW'(2);

  logic [WA_W-1:0]   mem_addr [DEPTH];
  logic [BE_W-1:0]   mem_be   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] tail_m1;
  logic [CW-1:0] count;

  logic [WA_W-1:0] st_word;
  logic [WA_W-1:0] ld_word;
  logic            merge_hit;
  logic            accept;
  logic            push;
  logic            pop;

  logic [NC-1:0]        cand_hit;
  logic [NC*BE_W-1:0]   cand_be;
  logic [NC*DATA_W-1:0] cand_data;
  logic [PW-1:0]        idx;
  logic [BE_W-1:0]      fwd_be;
  logic [DATA_W-1:0]    fwd_data;

  logic unused;
  assign unused = ^{st_addr[WLSB-1:0], ld_addr[WLSB-1:0]};

  assign st_word = st_addr[ADDR_W-1:WLSB];
  assign ld_word = ld_addr[ADDR_W-1:WLSB];
  assign tail_m1 = tail - 1'b1;

  // count >= 2 keeps the head out of reach of a merge
  assign merge_hit = st_valid && (count >= TWO)
                  && (st_word == mem_addr[tail_m1]);

  assign st_ready = (count < FULL) || merge_hit;
  assign accept   = st_valid && st_ready;
  assign push     = accept && !merge_hit && (st_be != '0);

  assign sb_empty    = (count == '0);
  assign sb_count    = count;
  assign sb_wr_valid = !sb_empty && !ld_valid;
  assign pop         = sb_wr_valid && sb_wr_gnt;

  assign sb_wr_addr = {mem_addr[head], {WLSB{1'b0}}};
  assign sb_wr_be   = mem_be[head];
  assign sb_wr_data = mem_data[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // entry storage carries no reset; count alone marks validity
  always_ff @(posedge clk) begin
    if (!rst && merge_hit) begin
      mem_be[tail_m1] <= mem_be[tail_m1] | st_be;
      for (int l = 0; l < BE_W; l++) begin
        if (st_be[l]) begin
          mem_data[tail_m1][l*8 +: 8] <= st_wdata[l*8 +: 8];
        end
      end
    end
    if (!rst && push) begin
      mem_addr[tail] <= st_word;
      mem_be[tail]   <= st_be;
      mem_data[tail] <= st_wdata;
    end
  end

  always_comb begin
    cand_hit  = '0;
    cand_be   = '0;
    cand_data = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      cand_hit[k] = (CW'(k) < count)
                 && (mem_addr[idx] == ld_word);
      cand_be[k*BE_W +: BE_W]       = mem_be[idx];
      cand_data[k*DATA_W +: DATA_W] = mem_data[idx];
    end
    cand_hit[DEPTH] = accept && (st_word == ld_word);
    cand_be[DEPTH*BE_W +: BE_W]       = st_be;
    cand_data[DEPTH*DATA_W +: DATA_W] = st_wdata;
  end

  sb_fwd_merge #(
    .N      (NC),
    .DATA_W (DATA_W),
    .BE_W   (BE_W)
  ) u_fwd (
    .hit      (cand_hit),
    .be       (cand_be),
    .data     (cand_data),
    .fwd_be   (fwd_be),
    .fwd_data (fwd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_fwd_be   <= '0;
      ld_fwd_data <= '0;
    end else if (ld_valid) begin
      ld_fwd_be   <= fwd_be;
      ld_fwd_data <= fwd_data;
    end else begin
      ld_fwd_be   <= '0;
      ld_fwd_data <= '0;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed-vector bench for store_buffer.
// Inputs change #1 after posedge; outputs checked #2 after.
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_fwd_be;
  logic [31:0] ld_fwd_data;
  logic        sb_wr_valid;
  logic        sb_wr_gnt;
  logic [31:0] sb_wr_addr;
  logic [3:0]  sb_wr_be;
  logic [31:0] sb_wr_data;
  logic [2:0]  sb_count;
  logic        sb_empty;

  int nvec;
  int nerr;

  store_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_fwd_be   (ld_fwd_be),
    .ld_fwd_data (ld_fwd_data),
    .sb_wr_valid (sb_wr_valid),
    .sb_wr_gnt   (sb_wr_gnt),
    .sb_wr_addr  (sb_wr_addr),
    .sb_wr_be    (sb_wr_be),
    .sb_wr_data  (sb_wr_data),
    .sb_count    (sb_count),
    .sb_empty    (sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic st(input logic [31:0] a,
                    input logic [3:0] b,
                    input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_be    = b;
    st_wdata = d;
  endtask

  task automatic st_off();
    st_valid = 1'b0;
    st_addr  = '0;
    st_be    = '0;
    st_wdata = '0;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    sb_wr_gnt = 1'b0;
    ld_valid = 1'b0;
    ld_addr = '0;
    st_off();
    tick();
    tick();
    rst = 1'b0;
    settle();
    check("rst_count", 32'(sb_count), 32'd0);
    check("rst_empty", 32'(sb_empty), 32'd1);
    check("rst_wrv", 32'(sb_wr_valid), 32'd0);
    check("rst_rdy", 32'(st_ready), 32'd1);
    check("rst_fbe", 32'(ld_fwd_be), 32'd0);
    check("rst_fdat", ld_fwd_data, 32'd0);

    // single store drains next cycle
    tick();
    st(32'h100, 4'hF, 32'hAABBCCDD);
    settle();
    check("t1_rdy", 32'(st_ready), 32'd1);
    check("t1_wrv0", 32'(sb_wr_valid), 32'd0);
    tick();
    st_off();
    settle();
    check("t1_wrv", 32'(sb_wr_valid), 32'd1);
    check("t1_addr", sb_wr_addr, 32'h100);
    check("t1_be", 32'(sb_wr_be), 32'hF);
    check("t1_data", sb_wr_data, 32'hAABBCCDD);
    sb_wr_gnt = 1'b1;
    tick();
    sb_wr_gnt = 1'b0;
    settle();
    check("t1_empty", 32'(sb_empty), 32'd1);

    // fill with loads holding the port
    ld_valid = 1'b1;
    ld_addr  = 32'h900;
    for (int i = 0; i < 4; i++) begin
      st(32'h500 + 32'(4*i), 4'hF, 32'h5000 + 32'(i));
      tick();
    end
    st_off();
    settle();
    check("t2_count", 32'(sb_count), 32'd4);
    check("t2_wrv", 32'(sb_wr_valid), 32'd0);
    st(32'h510, 4'hF, 32'h0);
    settle();
    check("t2_full", 32'(st_ready), 32'd0);
    st(32'h50C, 4'h1, 32'h000000EE);
    settle();
    check("t2_mrdy", 32'(st_ready), 32'd1);
    tick();
    st_off();
    settle();
    check("t2_mcnt", 32'(sb_count), 32'd4);
    // full plus pop still refuses a new word
    ld_valid = 1'b0;
    sb_wr_gnt = 1'b1;
    st(32'h600, 4'hF, 32'h0);
    settle();
    check("t2_pfull", 32'(st_ready), 32'd0);
    check("t2_pwrv", 32'(sb_wr_valid), 32'd1);
    tick();
    st_off();
    settle();
    check("t2_pcnt", 32'(sb_count), 32'd3);
    tick();
    tick();
    settle();
    check("t2_last", sb_wr_data, 32'h000050EE);
    tick();
    sb_wr_gnt = 1'b0;
    settle();
    check("t2_empty", 32'(sb_empty), 32'd1);

    // merge into tail-1
    st(32'h200, 4'hF, 32'h0);
    tick();
    st(32'h204, 4'hC, 32'h33440000);
    tick();
    st(32'h204, 4'h3, 32'h00001122);
    settle();
    check("t3_rdy", 32'(st_ready), 32'd1);
    tick();
    st_off();
    settle();
    check("t3_cnt", 32'(sb_count), 32'd2);
    ld_valid = 1'b1;
    ld_addr  = 32'h204;
    tick();
    ld_valid = 1'b0;
    settle();
    check("t3_fbe", 32'(ld_fwd_be), 32'hF);
    check("t3_fdat", ld_fwd_data, 32'h33441122);
    sb_wr_gnt = 1'b1;
    tick();
    settle();
    check("t3_addr", sb_wr_addr, 32'h204);
    check("t3_be", 32'(sb_wr_be), 32'hF);
    check("t3_data", sb_wr_data, 32'h33441122);
    tick();
    sb_wr_gnt = 1'b0;
    settle();
    check("t3_empty", 32'(sb_empty), 32'd1);

    // count 1: same word allocates, youngest lane wins
    st(32'h300, 4'hF, 32'h11111111);
    tick();
    st(32'h300, 4'h1, 32'h000000FF);
    tick();
    st_off();
    settle();
    check("t4_cnt", 32'(sb_count), 32'd2);
    ld_valid = 1'b1;
    ld_addr  = 32'h300;
    tick();
    ld_valid = 1'b0;
    settle();
    check("t4_fbe", 32'(ld_fwd_be), 32'hF);
    check("t4_fdat", ld_fwd_data, 32'h111111FF);
    tick();
    settle();
    check("t4_idle", 32'(ld_fwd_be), 32'h0);
    sb_wr_gnt = 1'b1;
    tick();
    tick();
    sb_wr_gnt = 1'b0;
    settle();
    check("t4_empty", 32'(sb_empty), 32'd1);

    // forward from the incoming store
    ld_valid = 1'b1;
    ld_addr  = 32'h400;
    st(32'h400, 4'h4, 32'h00AB0000);
    tick();
    st_off();
    ld_addr = 32'h404;
    settle();
    check("t5_fbe", 32'(ld_fwd_be), 32'h4);
    check("t5_fdat", ld_fwd_data, 32'h00AB0000);
    tick();
    ld_valid = 1'b0;
    settle();
    check("t5_mbe", 32'(ld_fwd_be), 32'h0);
    check("t5_mdat", ld_fwd_data, 32'h0);
    sb_wr_gnt = 1'b1;
    tick();
    sb_wr_gnt = 1'b0;
    settle();
    check("t5_empty", 32'(sb_empty), 32'd1);

    // reset mid-drain
    for (int i = 0; i < 3; i++) begin
      st(32'h700 + 32'(4*i), 4'hF, 32'(i));
      tick();
    end
    st_off();
    settle();
    check("t6_cnt", 32'(sb_count), 32'd3);
    rst = 1'b1;
    sb_wr_gnt = 1'b1;
    settle();
    check("t6_wrv", 32'(sb_wr_valid), 32'd1);
    tick();
    rst = 1'b0;
    sb_wr_gnt = 1'b0;
    settle();
    check("t6_rcnt", 32'(sb_count), 32'd0);
    check("t6_rwrv", 32'(sb_wr_valid), 32'd0);
    check("t6_rempty", 32'(sb_empty), 32'd1);
    tick();
    settle();
    check("t6_hold", 32'(sb_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Parametrised write buffer between the MEM stage and the data-SRAM bridge of the pipelined MIPS core. Committed stores are queued in a FIFO and drained to the data port in idle cycles, so loads get priority on the shared port. Stores to the same word as the newest entry are merged. Loads receive byte-granular forwarding from every pending store, aligned with the synchronous SRAM read data.

## Interface
- DEPTH, 4 — entries; power of two, ≥2.
- ADDR_W, 32 — byte-address width.
- DATA_W, 32 — data width; power of two, ≥8. BE_W = DATA_W/8; WLSB = log2(BE_W).
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- st_valid  in  1  committed store presented.
- st_ready  out  1  store accepted this cycle when st_valid && st_ready.
- st_addr  in  ADDR_W  store byte address; only [ADDR_W-1:WLSB] is used.
- st_be  in  BE_W  store byte enables; all-zero is accepted and dropped.
- st_wdata  in  DATA_W  store data, lane-aligned.
- ld_valid  in  1  load issuing to the SRAM this cycle.
- ld_addr  in  ADDR_W  load byte address.
- ld_fwd_be  out  BE_W  registered; lanes supplied by the buffer for the load issued last cycle.
- ld_fwd_data  out  DATA_W  registered; forwarded lane data, zero in lanes not forwarded.
- sb_wr_valid  out  1  head entry offered to the bridge.
- sb_wr_gnt  in  1  bridge took the data port; pop when sb_wr_valid && sb_wr_gnt.
- sb_wr_addr  out  ADDR_W  head word address; low WLSB bits are zero.
- sb_wr_be  out  BE_W  head byte enables.
- sb_wr_data  out  DATA_W  head data.
- sb_count  out  log2(DEPTH)+1  valid entries.
- sb_empty  out  1  sb_count==0.

## Operation
- Storage: circular FIFO of {word_addr, be, data} with head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus a count register.
- Drain: sb_wr_valid = !sb_empty && !ld_valid. This is combinational from the state and ld_valid; it never depends on sb_wr_gnt. The sb_wr_* fields come straight from the head entry.
- Accept: st_ready = (sb_count < DEPTH) || merge_hit. It never depends on sb_wr_gnt.
- Merge: merge_hit = st_valid && sb_count ≥ 2 && word_addr(st) == word_addr(tail-1). On a hit, lanes with st_be set overwrite the tail-1 data and be |= st_be. No allocation occurs. The head entry is never a merge target.
- Allocate: otherwise write the entry at tail, then tail+1 and count+1.
- Simultaneous push and pop: count is unchanged and both pointers advance. At DEPTH a non-merging store is still refused, even if a pop occurs the same cycle.
- Forward: when ld_valid, compare word_addr(ld) against all valid entries and against the incoming store (if st_valid && st_ready). For each lane, the youngest matching entry with that lane enabled supplies the data; the incoming store is youngest. Results are registered into ld_fwd_*. When !ld_valid, ld_fwd_be is 0 the next cycle.
- The bridge merges lane-wise: final = ld_fwd_be ? ld_fwd_data : data_sram_rdata.

## Timing
- Reset: head=tail=count=0, sb_empty=1, sb_wr_valid=0, st_ready=1, ld_fwd_be=0, ld_fwd_data=0. Contents are don't-care. Asserting rst mid-drain discards every entry, and the next cycle shows the reset values.
- Store-to-drain latency: an accepted store may appear on sb_wr_* the following cycle at the earliest.
- Forward latency: exactly 1 cycle after ld_valid, matching the synchronous SRAM read.
- A pop and a load never coincide, because load priority suppresses sb_wr_valid. The forwarded set therefore equals what the SRAM has not yet received.
- Throughput: one push and one pop per cycle.

## Structure
- Shared package: SB_DEPTH_DEFAULT, SB_DATA_W_DEFAULT, and the entry record layout {addr, be, data}, all reused by bridge_dm.
- Sub-module sb_fwd_merge: combinational youngest-first lane-priority selector taking (DEPTH+1) candidates ordered by age. It is instantiated once.

## Test plan
- Reset, then st 0x100 be=1111 data=0xAABBCCDD with ld_valid=0 → next cycle sb_wr_valid=1, addr=0x100, be=1111. On gnt, sb_empty=1.
- Fill 4 stores to distinct words with ld_valid held high → st_ready=0 at count 4 for a fifth distinct word. A fifth store to the tail-1 word is accepted (merge) and count stays 4.
- Two entries pending, then st 0x204 be=0011 data=0x00001122 after an entry 0x204 be=1100 data=0x33440000 → the tail entry becomes be=1111, data=0x33441122.
- Entries 0x300 be=1111 data=0x11111111, then 0x300 be=0001 data=0x000000FF (count 2, no merge), then ld 0x300 → the next cycle shows ld_fwd_be=1111, ld_fwd_data=0x111111FF.
- Load 0x400 issued in the same cycle as st 0x400 be=0100 data=0x00AB0000 → ld_fwd_be=0100, ld_fwd_data=0x00AB0000. Load 0x404 → ld_fwd_be=0000.
- Assert rst with 3 entries pending → the next cycle shows sb_count=0, sb_wr_valid=0, and no sb_wr_gnt pop is recorded.
